calc_mem_loader: RTL and testbench

Upstream preload stage for the calculator. It accepts a valid/ready stream of 64-bit operand words and writes them into a contiguous address window of the split SRAM pair through write port 0. It holds the calculator in reset until the last word has settled in memory, then releases it. It also reports completion and error status to the testbench or SoC host.

---
 rtl/calc_mem_loader.sv | 153 +++++++++++++++
 tb/tb_calc_mem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_mem_loader.sv
// calc_mem_loader: preload stage for the calculator.
// Accepts a valid/ready stream of 64-bit words and writes them into a
// contiguous SRAM address window through write port 0. The calculator core
// is held in reset until the final word has been written to memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds checksum_o, a running
// 32-bit sum of both halves of every accepted word.
module calc_mem_loader #(
    parameter int ADDR_W        = 9,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    input  logic                     abort_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [MEM_WORD_SIZE-1:0] in_data_i,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [MEM_WORD_SIZE-1:0] w_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     calc_rst_o,
    output logic                     err_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]              checksum_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
    logic                     write_q, write_d;
    logic [ADDR_W-1:0]        w_addr_q, w_addr_d;
    logic [MEM_WORD_SIZE-1:0] w_data_q, w_data_d;
    logic                     err_q, err_d;

    // An empty or reversed window is rejected as an error.
    logic start_ok;
    assign start_ok = start_i && (start_addr_i <= end_addr_i);

    // State and datapath registers; reset drops any pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            write_q    <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            write_q    <= write_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: session control, write registration, error flag.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        write_d    = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        err_d      = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    cur_addr_d = start_addr_i;
                    end_addr_d = end_addr_i;
                    err_d      = 1'b0;
                    state_d    = LOAD;
                end else if (start_i) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                // Abort wins over a same-cycle handshake; that word is dropped.
                if (abort_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (in_valid_i) begin
                    write_d  = 1'b1;
                    w_addr_d = cur_addr_q;
                    w_data_d = in_data_i;
                    // Stop at the end address rather than incrementing, so
                    // a window ending at the top of memory never wraps.
                    if (cur_addr_q == end_addr_q) begin
                        state_d = DRAIN;
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                // The final write is on the port this cycle.
                if (abort_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o = (state_q == LOAD);
    assign busy_o     = (state_q == LOAD) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);
    assign calc_rst_o = rst_i || (state_q != DONE);
    assign write_o    = write_q;
    assign w_addr_o   = w_addr_q;
    assign w_data_o   = w_data_q;
    assign err_o      = err_q;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        sum_clr;
    logic        sum_add;

    assign sum_clr = start_ok && ((state_q == IDLE) || (state_q == DONE));
    assign sum_add = (state_q == LOAD) && in_valid_i && !abort_i;

    // Running modular sum of both word halves over accepted words.
    always_ff @(posedge clk_i) begin
        if (rst_i || sum_clr) begin
            sum_q <= '0;
        end else if (sum_add) begin
            sum_q <= sum_q + in_data_i[31:0] + in_data_i[MEM_WORD_SIZE-1:32];
        end
    end

    assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_calc_mem_loader.sv
// Self-checking bench for calc_mem_loader: directed sessions plus randomized
// windows, gaps and data, checked against a word-list reference model.
`timescale 1ns/1ps
module tb_calc_mem_loader;
    localparam int ADDR_W = 9;
    localparam int MW     = 64;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] start_addr_i = '0;
    logic [ADDR_W-1:0] end_addr_i = '0;
    logic              abort_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic [MW-1:0]     in_data_i = '0;
    logic              in_ready_o, write_o, busy_o, done_o, calc_rst_o, err_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [MW-1:0]     w_data_o;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       checksum_o;
`endif

    calc_mem_loader #(.ADDR_W(ADDR_W), .MEM_WORD_SIZE(MW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .abort_i(abort_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .write_o(write_o), .w_addr_o(w_addr_o),
        .w_data_o(w_data_o), .busy_o(busy_o), .done_o(done_o),
        .calc_rst_o(calc_rst_o), .err_o(err_o)
`ifdef LOADER_CHECKSUM_EN
        , .checksum_o(checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [MW-1:0]     data;
        int                cyc;
    } wr_t;

    wr_t         wr_log[$];
    logic [MW-1:0] sram [512];
    logic [MW-1:0] fixed_q[$];

    // Behaves like SRAM port 0: record every strobed write.
    always @(negedge clk_i) begin
        if (write_o === 1'b1) begin
            wr_log.push_back('{w_addr_o, w_data_o, cyc});
            sram[w_addr_o] <= w_data_o;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic b, input logic d,
                            input logic r, input logic e, input logic c);
        check($sformatf("%s.busy", tag),     64'(busy_o),     64'(b));
        check($sformatf("%s.done", tag),     64'(done_o),     64'(d));
        check($sformatf("%s.ready", tag),    64'(in_ready_o), 64'(r));
        check($sformatf("%s.err", tag),      64'(err_o),      64'(e));
        check($sformatf("%s.calc_rst", tag), 64'(calc_rst_o), 64'(c));
    endtask

    task automatic check_reset_vals(input string tag);
        check_st(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check($sformatf("%s.write", tag),  64'(write_o),  64'(0));
        check($sformatf("%s.w_addr", tag), 64'(w_addr_o), 64'(0));
        check($sformatf("%s.w_data", tag), w_data_o,      64'(0));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One load session. mode 0: valid always high, 1: valid from vpat bits
    // (LSB first), 2: random valid. abort_k / rst_k: index of the handshake
    // attempt that is hit by abort_i / rst_i (-1 for none).
    task automatic load(input int s, input int e, input int mode, input logic [31:0] vpat,
                        input int abort_k, input int rst_k);
        int n = e - s + 1;
        int k = 0;
        int step = 0;
        bit cut = 0;
        logic v;
        logic [MW-1:0] d;
        wr_t exp_q[$];
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] csum = '0;
`endif
        wr_log.delete();
        start_i = 1'b1;
        start_addr_i = ADDR_W'(s);
        end_addr_i = ADDR_W'(e);
        tick();
        start_i = 1'b0;
        check_st($sformatf("start[%0h..%0h]", s, e), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        while (k < n) begin
            if (step > 40 * n + 100) begin
                check("load.timeout", 64'(k), 64'(n));
                cut = 1;
                break;
            end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? vpat[step % 32] : ($urandom_range(0, 3) != 0);
            d = (v && fixed_q.size() > 0) ? fixed_q.pop_front() : {$urandom, $urandom};
            check($sformatf("ready[k=%0d]", k), 64'(in_ready_o), 64'(1));
            in_valid_i = v;
            in_data_i = d;
            if (v && k == abort_k) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                in_valid_i = 1'b0;
                check_st("abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                cut = 1;
                break;
            end
            if (v && k == rst_k) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                in_valid_i = 1'b0;
                check_reset_vals("midrst");
                cut = 1;
                break;
            end
            if (v) begin
                exp_q.push_back('{ADDR_W'(s + k), d, cyc + 1});
`ifdef LOADER_CHECKSUM_EN
                csum += d[31:0] + d[63:32];
`endif
                k++;
            end
            step++;
            tick();
        end
        in_valid_i = 1'b0;
        if (!cut) begin
            check_st("drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            check_st("done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
            check("checksum", 64'(checksum_o), 64'(csum));
`endif
        end
        tick();
        check("wr_count", 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            check($sformatf("wr[%0d].addr", i), 64'(wr_log[i].addr), 64'(exp_q[i].addr));
            check($sformatf("wr[%0d].data", i), wr_log[i].data, exp_q[i].data);
            check($sformatf("wr[%0d].cyc", i), 64'(wr_log[i].cyc), 64'(exp_q[i].cyc));
            check($sformatf("readback[%0h]", exp_q[i].addr), sram[exp_q[i].addr], exp_q[i].data);
        end
    endtask

    task automatic bad_start(input int s, input int e, input logic in_done);
        wr_log.delete();
        start_i = 1'b1;
        start_addr_i = ADDR_W'(s);
        end_addr_i = ADDR_W'(e);
        tick();
        start_i = 1'b0;
        check_st("bad_start", 1'b0, in_done, 1'b0, 1'b1, !in_done);
        tick();
        check("bad_start.writes", 64'(wr_log.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_i = 1'b0;
        tick();
        check_reset_vals("idle");

        load(16, 19, 0, 32'h0, -1, -1);          // basic 0x10..0x13
        load(0, 2, 1, 32'h19, -1, -1);           // valid 1,0,0,1,1
        bad_start(32, 31, 1'b1);                 // invalid window from DONE
        load(0, 7, 0, 32'h0, 2, -1);             // abort on 3rd handshake

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_vals("reset2");
        bad_start(32, 31, 1'b0);                 // invalid window from IDLE
        load(32, 35, 2, 32'h0, -1, -1);          // valid start clears err

        for (int t = 0; t < 6; t++) begin
            s = int'($urandom_range(0, 480));
            e = s + int'($urandom_range(0, 30));
            load(s, e, 2, 32'h0, -1, -1);
        end

        load(0, 511, 0, 32'h0, -1, -1);          // full depth
        load(0, 511, 0, 32'h0, -1, 100);         // reset at word 100

        fixed_q.push_back(64'h00000001_00000002);
        fixed_q.push_back(64'hFFFFFFFF_00000001);
        load(64, 65, 0, 32'h0, -1, -1);
`ifdef LOADER_CHECKSUM_EN
        check("checksum.fixed", 64'(checksum_o), 64'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
